instr_stream_issuer: RTL and testbench
======================================

// Module: instr_stream_issuer
// PURPOSE
//   CPU-loaded program store and sequencer that drives the instruction AXIS bus
//   and the run_trig/run_done handshake of the experiment FSM.
//   Software writes N instruction words into a local RAM, sets length and pass count, then pulses start.
//   The block raises run_trig and streams the program loop_count times with full backpressure support.
//   It then drops tvalid, waits for run_done and reports completion.
// PARAMETERS
//   INSTR_W     17   instruction word width (bits [15:0] opcode flags, bit 16 reserved)
//   ADDR_W      8    program RAM address width; depth = 2**ADDR_W
//   LOOP_W      16   pass counter width
// PORTS
//   clk               in   1        system clock
//   rst               in   1        asynchronous reset, active low
//   prog_wr_en        in   1        program RAM write strobe
//   prog_wr_addr      in   ADDR_W   program RAM write address
//   prog_wr_data      in   INSTR_W  program RAM write data
//   prog_len          in   ADDR_W+1 number of words per pass (1..2**ADDR_W)
//   loop_count        in   LOOP_W   number of passes (>=1)
//   start             in   1        start request, sampled in IDLE
//   abort             in   1        abort request, any state
//   instr_axis_tdata  out  INSTR_W  instruction word
//   instr_axis_tvalid out  1        instruction valid
//   instr_axis_tready in   1        instruction ready (from experiment FSM)
//   run_trig          out  1        run request level to experiment FSM
//   run_done          in   1        experiment FSM finished
//   busy              out  1        high in any state except IDLE
//   done              out  1        high in DONE state
//   cfg_err           out  1        sticky: start seen with prog_len==0, prog_len>2**ADDR_W or loop_count==0
//   pass_cnt          out  LOOP_W   completed passes in current/last run
// BEHAVIOUR
//   Reset (rst low, async): state=IDLE; tdata=0, tvalid=0, run_trig=0, busy=0, done=0, cfg_err=0, pass_cnt=0. RAM contents undefined.
//   RAM: single write port, synchronous read (1 cycle). prog_wr_en honoured only in IDLE/DONE; ignored while busy.
//   States:
//   - IDLE: on start with valid cfg -> latch prog_len/loop_count, clear pass_cnt, rd_addr=0, run_trig<=1 -> FETCH.
//     Invalid cfg -> set cfg_err, stay IDLE. cfg_err clears on the next valid start.
//   - FETCH: issue RAM read of addr 0 -> STREAM. First tvalid rises 2 cycles after start sampled.
//   - STREAM: word transfers on tvalid&&tready. While tvalid&&!tready, tdata and tvalid are held stable.
//     Prefetch/skid so that with tready held high, words issue back-to-back at 1 per cycle with no bubbles,
//     including across pass boundaries. After word prog_len-1, address wraps to 0 and pass_cnt increments
//     (on the final word's handshake cycle). When pass_cnt reaches loop_count: tvalid<=0 next cycle -> WAIT_DONE.
//   - WAIT_DONE: tvalid=0, run_trig held 1; on run_done=1 -> run_trig<=0 -> DONE.
//   - DONE: done=1; when start=0 -> IDLE (start must be released before re-arming; no auto-restart on held start).
//   abort (any busy state): next cycle tvalid=0, run_trig=0 -> IDLE. pass_cnt frozen. A word presented in the
//     abort cycle with tready high counts as transferred. abort has priority over start in the same cycle.
//   Exactly prog_len*loop_count handshakes occur per unaborted run; no extra or duplicated words.
//   tdata is X-free: 0 whenever tvalid=0.
//   Single-word program (prog_len=1) must still stream one word per cycle under tready=1.
// TESTING
//   1. Load 4 words 0x00001,0x00008,0x00081,0x00006; len=4, loops=1, tready=1 -> 4 consecutive beats in order; run_trig=1 until run_done pulse, then done=1.
//   2. Same program, loops=3, tready=1 -> 12 contiguous beats (pattern repeated 3x); pass_cnt=3.
//   3. len=4, loops=2, tready random 50% -> same 8-word sequence; tdata stable whenever tvalid&&!tready.
//   4. start with prog_len=0 (then loop_count=0) -> cfg_err=1, tvalid/run_trig never rise, state stays IDLE.
//   5. len=16, loops=4, assert abort after beat 20 -> tvalid and run_trig low next cycle; busy=0; pass_cnt=1; restart runs cleanly.
//   6. Async reset mid-STREAM (rst low 3 cycles) -> all outputs 0 immediately; prog_wr_en during STREAM has no effect on streamed data.

Source files
------------

// File: rtl/instr_stream_issuer.sv
// Program-RAM sequencer: streams a CPU-loaded instruction program loop_count times
// over an AXIS-style bus and handshakes the run with the experiment FSM.
module instr_stream_issuer #(
  parameter int INSTR_W = 17,
  parameter int ADDR_W  = 8,
  parameter int LOOP_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               prog_wr_en,
  input  logic [ADDR_W-1:0]  prog_wr_addr,
  input  logic [INSTR_W-1:0] prog_wr_data,
  input  logic [ADDR_W:0]    prog_len,
  input  logic [LOOP_W-1:0]  loop_count,
  input  logic               start,
  input  logic               abort,
  output logic [INSTR_W-1:0] instr_axis_tdata,
  output logic               instr_axis_tvalid,
  input  logic               instr_axis_tready,
  output logic               run_trig,
  input  logic               run_done,
  output logic               busy,
  output logic               done,
  output logic               cfg_err,
  output logic [LOOP_W-1:0]  pass_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] C_DEPTH = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_STREAM,
    S_WAIT_DONE,
    S_DONE
  } state_t;

  state_t               r_state;
  logic [INSTR_W-1:0]   r_mem [DEPTH];
  logic [INSTR_W-1:0]   r_ram_q;
  logic [INSTR_W-1:0]   r_tdata;
  logic                 r_tvalid;
  logic                 r_run_trig;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_cfg_err;
  logic [LOOP_W-1:0]    r_pass_cnt;
  logic [ADDR_W:0]      r_len;
  logic [LOOP_W-1:0]    r_loops;
  logic [ADDR_W-1:0]    r_raddr;
  logic [LOOP_W-1:0]    r_ld_pass;
  logic                 r_out_last;

  logic                 w_cfg_ok;
  logic                 w_wr_ok;
  logic                 w_rd_last;
  logic [ADDR_W-1:0]    w_rd_next;
  logic                 w_load;
  logic                 w_hs;
  logic                 w_pass_end;
  logic                 w_run_end;
  logic [ADDR_W-1:0]    w_raddr;

  assign w_cfg_ok   = (prog_len != '0) && (prog_len <= C_DEPTH) && (loop_count != '0);
  assign w_wr_ok    = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_rd_last  = ({1'b0, r_raddr} == (r_len - 1'b1));
  assign w_rd_next  = w_rd_last ? '0 : r_raddr + 1'b1;
  // r_ram_q always holds the word at r_raddr; the output register refills from it
  // whenever it is empty or being consumed, so tready=1 gives one word per cycle.
  assign w_load     = (r_state == S_STREAM) && (!r_tvalid || instr_axis_tready) &&
                      (r_ld_pass != r_loops);
  assign w_hs       = (r_state == S_STREAM) && r_tvalid && instr_axis_tready;
  assign w_pass_end = w_hs && r_out_last;
  assign w_run_end  = w_pass_end && ((r_pass_cnt + 1'b1) == r_loops);
  assign w_raddr    = (r_state != S_STREAM) ? '0 : (w_load ? w_rd_next : r_raddr);

  always_ff @(posedge clk) begin
    if (prog_wr_en && w_wr_ok) r_mem[prog_wr_addr] <= prog_wr_data;
    r_ram_q <= r_mem[w_raddr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_tdata    <= '0;
      r_tvalid   <= 1'b0;
      r_run_trig <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_cfg_err  <= 1'b0;
      r_pass_cnt <= '0;
      r_len      <= '0;
      r_loops    <= '0;
      r_raddr    <= '0;
      r_ld_pass  <= '0;
      r_out_last <= 1'b0;
    end else if (abort && (r_state != S_IDLE)) begin
      // The word on the bus in the abort cycle still counts if it handshakes.
      if (w_pass_end) r_pass_cnt <= r_pass_cnt + 1'b1;
      r_state    <= S_IDLE;
      r_tdata    <= '0;
      r_tvalid   <= 1'b0;
      r_run_trig <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            if (w_cfg_ok) begin
              r_len      <= prog_len;
              r_loops    <= loop_count;
              r_pass_cnt <= '0;
              r_ld_pass  <= '0;
              r_raddr    <= '0;
              r_run_trig <= 1'b1;
              r_busy     <= 1'b1;
              r_cfg_err  <= 1'b0;
              r_state    <= S_FETCH;
            end else begin
              r_cfg_err <= 1'b1;
            end
          end
        end
        S_FETCH: r_state <= S_STREAM;
        S_STREAM: begin
          if (w_pass_end) r_pass_cnt <= r_pass_cnt + 1'b1;
          if (w_load) begin
            r_tdata    <= r_ram_q;
            r_tvalid   <= 1'b1;
            r_out_last <= w_rd_last;
            r_raddr    <= w_rd_next;
            if (w_rd_last) r_ld_pass <= r_ld_pass + 1'b1;
          end else if (w_hs) begin
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
          end
          if (w_run_end) r_state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (run_done) begin
            r_run_trig <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= S_DONE;
          end
        end
        S_DONE: begin
          if (!start) begin
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign instr_axis_tdata  = r_tdata;
  assign instr_axis_tvalid = r_tvalid;
  assign run_trig          = r_run_trig;
  assign busy              = r_busy;
  assign done              = r_done;
  assign cfg_err           = r_cfg_err;
  assign pass_cnt          = r_pass_cnt;

endmodule

// File: tb/tb_instr_stream_issuer.sv
// Scoreboard bench for instr_stream_issuer: the expected word stream is the program
// repeated loop_count times; a negedge monitor checks every handshake against it.
module tb_instr_stream_issuer;
  localparam int INSTR_W = 17;
  localparam int ADDR_W  = 8;
  localparam int LOOP_W  = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               prog_wr_en;
  logic [ADDR_W-1:0]  prog_wr_addr;
  logic [INSTR_W-1:0] prog_wr_data;
  logic [ADDR_W:0]    prog_len;
  logic [LOOP_W-1:0]  loop_count;
  logic               start;
  logic               abort;
  logic [INSTR_W-1:0] instr_axis_tdata;
  logic               instr_axis_tvalid;
  logic               instr_axis_tready;
  logic               run_trig;
  logic               run_done;
  logic               busy;
  logic               done;
  logic               cfg_err;
  logic [LOOP_W-1:0]  pass_cnt;

  instr_stream_issuer #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .LOOP_W(LOOP_W)) dut (
    .clk(clk), .rst(rst),
    .prog_wr_en(prog_wr_en), .prog_wr_addr(prog_wr_addr), .prog_wr_data(prog_wr_data),
    .prog_len(prog_len), .loop_count(loop_count), .start(start), .abort(abort),
    .instr_axis_tdata(instr_axis_tdata), .instr_axis_tvalid(instr_axis_tvalid),
    .instr_axis_tready(instr_axis_tready), .run_trig(run_trig), .run_done(run_done),
    .busy(busy), .done(done), .cfg_err(cfg_err), .pass_cnt(pass_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int hs_cnt = 0;
  int first_hs = 0;
  int last_hs = 0;
  bit rdy_mode = 1'b0;
  logic prev_stall = 1'b0;
  logic [INSTR_W-1:0] prev_data = '0;
  logic [INSTR_W-1:0] exp_q [$];
  logic [INSTR_W-1:0] prog [256];

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    instr_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      instr_axis_tready = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: stability under backpressure, zero data when idle, and in-order beats.
  always @(negedge clk) begin
    logic [INSTR_W-1:0] exp_w;
    if (rst) begin
      if (prev_stall) begin
        check("hold_tvalid", 64'(instr_axis_tvalid), 64'd1);
        check("hold_tdata", 64'(instr_axis_tdata), 64'(prev_data));
      end
      if (!instr_axis_tvalid) check("tdata_zero_when_idle", 64'(instr_axis_tdata), 64'd0);
      if (instr_axis_tvalid && instr_axis_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'(exp_q.size()), 64'd1);
        end else begin
          exp_w = exp_q.pop_front();
          check("beat_data", 64'(instr_axis_tdata), 64'(exp_w));
        end
        if (hs_cnt == 0) first_hs = cyc;
        last_hs = cyc;
        hs_cnt++;
      end
      prev_stall = instr_axis_tvalid && !instr_axis_tready;
      prev_data  = instr_axis_tdata;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_word(int addr, logic [INSTR_W-1:0] data);
    prog_wr_en   = 1'b1;
    prog_wr_addr = ADDR_W'(addr);
    prog_wr_data = data;
    tick();
    prog_wr_en = 1'b0;
  endtask

  task automatic load_random(int len);
    for (int i = 0; i < len; i++) begin
      prog[i] = INSTR_W'($urandom);
      write_word(i, prog[i]);
    end
  endtask

  // Reference model: the stream is simply prog[i mod len] for i < len*loops.
  task automatic start_run(int len, int loops, bit hold);
    prog_len   = (ADDR_W+1)'(len);
    loop_count = LOOP_W'(loops);
    for (int i = 0; i < len * loops; i++) exp_q.push_back(prog[i % len]);
    hs_cnt = 0;
    start  = 1'b1;
    tick();
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_hs(int n);
    int t = 0;
    while (hs_cnt < n && t < 5000) begin
      tick();
      t++;
    end
    check("beats_reached", 64'(hs_cnt >= n), 64'd1);
  endtask

  task automatic finish_run(int total, int loops, bit contig, bit hold);
    wait_hs(total);
    tick(2);
    check("wait_tvalid_low", 64'(instr_axis_tvalid), 64'd0);
    check("wait_run_trig", 64'(run_trig), 64'd1);
    check("wait_busy", 64'(busy), 64'd1);
    check("wait_not_done", 64'(done), 64'd0);
    check("pass_cnt_final", 64'(pass_cnt), 64'(loops));
    check("exp_queue_drained", 64'(exp_q.size()), 64'd0);
    if (contig) check("no_bubbles", 64'(last_hs - first_hs), 64'(total - 1));
    run_done = 1'b1;
    tick();
    run_done = 1'b0;
    check("done_run_trig", 64'(run_trig), 64'd0);
    check("done_flag", 64'(done), 64'd1);
    if (hold) begin
      tick(3);
      check("done_held_start", 64'(done), 64'd1);
      start = 1'b0;
    end
    tick();
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_done", 64'(done), 64'd0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; run_done = 1'b0;
    prog_wr_en = 1'b0; prog_wr_addr = '0; prog_wr_data = '0;
    prog_len = '0; loop_count = '0;
    #12;
    check("rst_tdata", 64'(instr_axis_tdata), 64'd0);
    check("rst_tvalid", 64'(instr_axis_tvalid), 64'd0);
    check("rst_run_trig", 64'(run_trig), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_cfg_err", 64'(cfg_err), 64'd0);
    check("rst_pass_cnt", 64'(pass_cnt), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    tick();

    // Fixed 4-word program, single pass, start held through DONE.
    prog[0] = 17'h00001; prog[1] = 17'h00008; prog[2] = 17'h00081; prog[3] = 17'h00006;
    for (int i = 0; i < 4; i++) write_word(i, prog[i]);
    start_run(4, 1, 1'b1);
    check("start_busy", 64'(busy), 64'd1);
    check("start_run_trig", 64'(run_trig), 64'd1);
    check("start_tvalid_low0", 64'(instr_axis_tvalid), 64'd0);
    tick();
    check("start_tvalid_low1", 64'(instr_axis_tvalid), 64'd0);
    tick();
    check("first_tvalid", 64'(instr_axis_tvalid), 64'd1);
    check("first_tdata", 64'(instr_axis_tdata), 64'h1);
    finish_run(4, 1, 1'b1, 1'b1);

    // Zero length is rejected without leaving IDLE.
    prog_len = '0; loop_count = 16'd1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(3);
    check("len0_cfg_err", 64'(cfg_err), 64'd1);
    check("len0_busy", 64'(busy), 64'd0);
    check("len0_run_trig", 64'(run_trig), 64'd0);
    check("len0_tvalid", 64'(instr_axis_tvalid), 64'd0);

    // Three passes back-to-back; a valid start clears cfg_err.
    start_run(4, 3, 1'b0);
    check("cfg_err_cleared", 64'(cfg_err), 64'd0);
    finish_run(12, 3, 1'b1, 1'b0);

    // Random backpressure.
    rdy_mode = 1'b1;
    start_run(4, 2, 1'b0);
    finish_run(8, 2, 1'b0, 1'b0);
    rdy_mode = 1'b0;

    // Single-word program still streams every cycle.
    prog[0] = INSTR_W'($urandom);
    write_word(0, prog[0]);
    start_run(1, 5, 1'b0);
    finish_run(5, 5, 1'b1, 1'b0);

    // Zero loop count and oversize length are rejected.
    prog_len = 9'd4; loop_count = '0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(3);
    check("loops0_cfg_err", 64'(cfg_err), 64'd1);
    check("loops0_busy", 64'(busy), 64'd0);
    prog_len = 9'd257; loop_count = 16'd1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(3);
    check("len257_cfg_err", 64'(cfg_err), 64'd1);
    check("len257_run_trig", 64'(run_trig), 64'd0);

    // Full-depth program, random backpressure.
    rdy_mode = 1'b1;
    load_random(256);
    start_run(256, 2, 1'b0);
    finish_run(512, 2, 1'b0, 1'b0);
    rdy_mode = 1'b0;

    // Abort after 20 beats; the beat in the abort cycle is transferred.
    load_random(16);
    start_run(16, 4, 1'b0);
    wait_hs(20);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_tvalid", 64'(instr_axis_tvalid), 64'd0);
    check("abort_run_trig", 64'(run_trig), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_beats", 64'(hs_cnt), 64'd21);
    check("abort_pass_cnt", 64'(pass_cnt), 64'(hs_cnt / 16));
    check("abort_remaining", 64'(exp_q.size()), 64'(64 - hs_cnt));
    exp_q.delete();
    tick(4);
    check("abort_pass_frozen", 64'(pass_cnt), 64'd1);
    start_run(16, 1, 1'b0);
    finish_run(16, 1, 1'b1, 1'b0);

    // RAM writes during streaming are ignored; async reset mid-stream.
    load_random(4);
    start_run(4, 50, 1'b0);
    wait_hs(10);
    for (int i = 0; i < 4; i++) write_word(i, ~prog[i]);
    wait_hs(30);
    #3;
    rst = 1'b0;
    #1;
    check("arst_tdata", 64'(instr_axis_tdata), 64'd0);
    check("arst_tvalid", 64'(instr_axis_tvalid), 64'd0);
    check("arst_run_trig", 64'(run_trig), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_cfg_err", 64'(cfg_err), 64'd0);
    check("arst_pass_cnt", 64'(pass_cnt), 64'd0);
    tick(3);
    exp_q.delete();
    rst = 1'b1;
    tick();
    rdy_mode = 1'b1;
    load_random(4);
    start_run(4, 2, 1'b0);
    finish_run(8, 2, 1'b0, 1'b0);
    rdy_mode = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
